// File: rtl/ct_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
package ct_seq_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // Sequence mode, latched at start
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/ct_seq_ctrl_if.sv
// Bundle of control, counter-side and status signals around ct_seq_ctrl.
// The master modport is the controller; the slave modport is its environment
// (user control inputs plus the attached counter).
interface ct_seq_ctrl_if #(
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [WIDTH-1:0]   preset;
  logic [WIDTH-1:0]   count;
  logic               carry_in;
  logic               enable_l;
  logic               load;
  logic [WIDTH-1:0]   data;
  logic               busy;
  logic               tick;
  logic [TALLY_W-1:0] tally;

  modport master (
    input  start, stop, mode, preset, count, carry_in,
    output enable_l, load, data, busy, tick, tally
  );

  modport slave (
    output start, stop, mode, preset, count, carry_in,
    input  enable_l, load, data, busy, tick, tally
  );
endinterface

// File: rtl/ct_seq_ctrl_sat_tally.sv
// Saturating event counter with synchronous clear, clocked on the falling
// edge of clk_l like the rest of the controller.
module ct_seq_ctrl_sat_tally #(
  parameter int W = 8
) (
  input  logic         clk_l,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Clear wins over increment; once all-ones the value sticks until cleared
  always_ff @(negedge clk_l) begin
    if (reset || clr) begin
      value <= '0;
    end else if (inc && !(&value)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/ct_seq_ctrl.sv
// Sequencing controller for a load/enable up-counter: one-shot or periodic
// (auto-reload) runs, start/stop control, terminal-count tick and tally.
module ct_seq_ctrl
  import ct_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 8
) (
  input logic           clk_l,
  input logic           reset,
  ct_seq_ctrl_if.master bus
);

  state_t             state_reg;
  logic               mode_q;
  logic [WIDTH-1:0]   preset_q;
  logic               busy_reg;
  logic               tick_reg;
  logic               enable_l_c;
  logic               load_c;
  logic               terminal;
  logic               tally_clr;
  logic [TALLY_W-1:0] tally_val;

  // Counter controls decoded from the current state so they act on the very
  // edge where the terminal value is present; carry_in only matters in RUN.
  always_comb begin
    enable_l_c = 1'b1;
    load_c     = 1'b0;
    terminal   = 1'b0;
    case (state_reg)
      LOAD: load_c = 1'b1;
      RUN: begin
        if (!bus.stop) begin
          if (bus.carry_in) begin
            terminal = 1'b1;
            load_c   = (mode_q == MODE_PERIODIC);
          end else begin
            enable_l_c = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign tally_clr = ((state_reg == IDLE) || (state_reg == HALT)) && bus.start;

  // State register with registered busy/tick and latched start parameters
  always_ff @(negedge clk_l) begin
    if (reset) begin
      state_reg <= IDLE;
      mode_q    <= MODE_ONESHOT;
      preset_q  <= '0;
      busy_reg  <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= terminal;
      case (state_reg)
        IDLE, HALT: begin
          if (bus.start) begin
            preset_q  <= bus.preset;
            mode_q    <= bus.mode;
            busy_reg  <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (bus.stop) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (bus.carry_in && (mode_q == MODE_ONESHOT)) begin
            busy_reg  <= 1'b0;
            state_reg <= HALT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  ct_seq_ctrl_sat_tally #(
    .W (TALLY_W)
  ) u_tally (
    .clk_l (clk_l),
    .reset (reset),
    .clr   (tally_clr),
    .inc   (terminal),
    .value (tally_val)
  );

  assign bus.enable_l = enable_l_c;
  assign bus.load     = load_c;
  assign bus.data     = preset_q;
  assign bus.busy     = busy_reg;
  assign bus.tick     = tick_reg;
  assign bus.tally    = tally_val;

endmodule
